// File: rtl/rrv64_vec_opnd_collector.sv
// Operand collector: latches one uop, issues tagged VRF reads per source lane, gathers the tagged data.
// Latency: uop accept to opnd_vld is 1 cycle with no sources, otherwise 3 cycles minimum.
// Backpressure: uop_rdy only in IDLE; opnd_* held stable while opnd_rdy is low; requests held until granted.
module rrv64_vec_opnd_collector #(
  parameter int VFULEN          = 256,
  parameter int VREG_ADDR_WIDTH = 6,
  parameter int VSB_ENT_NUM     = 16,
  parameter int NSRC            = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            uop_vld,
  output logic                            uop_rdy,
  input  logic [VSB_ENT_NUM-1:0]          uop_vsb_idx,
  input  logic [NSRC-1:0]                 uop_src_vld,
  input  logic [NSRC*VREG_ADDR_WIDTH-1:0] uop_src_vaddr,
  output logic [NSRC-1:0]                 rd_req_vld,
  output logic [NSRC*VREG_ADDR_WIDTH-1:0] rd_req_vaddr,
  output logic [NSRC*VSB_ENT_NUM-1:0]     rd_req_rs_idx,
  output logic [NSRC*2-1:0]               rd_req_field,
  input  logic [NSRC-1:0]                 rd_req_gnt,
  input  logic [NSRC-1:0]                 rd_rsp_vld,
  input  logic [NSRC*VFULEN-1:0]          rd_rsp_data,
  input  logic [NSRC*VSB_ENT_NUM-1:0]     rd_rsp_rs_idx,
  input  logic [NSRC*2-1:0]               rd_rsp_field,
  output logic                            opnd_vld,
  input  logic                            opnd_rdy,
  output logic [VSB_ENT_NUM-1:0]          opnd_vsb_idx,
  output logic [NSRC-1:0]                 opnd_src_vld,
  output logic [NSRC*VFULEN-1:0]          opnd_data
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SEND, S_DRAIN} state_t;

  state_t                          r_state;
  logic [VSB_ENT_NUM-1:0]          r_tag;
  logic [NSRC-1:0]                 r_src_vld;
  logic [NSRC*VREG_ADDR_WIDTH-1:0] r_vaddr;
  logic [NSRC-1:0]                 r_need_req;
  logic [NSRC-1:0]                 r_need_rsp;
  logic [NSRC-1:0]                 r_inflight;
  logic [NSRC*VFULEN-1:0]          r_data;
  logic                            r_opnd_vld;

  logic [NSRC-1:0]                 w_hit_slot;
  logic [NSRC*VFULEN-1:0]          w_hit_data;
  logic [NSRC-1:0]                 w_take;
  logic [NSRC-1:0]                 w_grant;
  logic [NSRC-1:0]                 w_need_rsp_nx;
  logic [NSRC-1:0]                 w_inflight_nx;

  // Route each returning lane to its field slot; the lowest lane wins when two target one slot.
  always_comb begin
    w_hit_slot = '0;
    w_hit_data = '0;
    for (int j = 0; j < NSRC; j++) begin
      for (int f = 0; f < NSRC; f++) begin
        if (rd_rsp_vld[j] &&
            (rd_rsp_rs_idx[j*VSB_ENT_NUM +: VSB_ENT_NUM] == r_tag) &&
            (rd_rsp_field[j*2 +: 2] == 2'(f)) && !w_hit_slot[f]) begin
          w_hit_slot[f]                 = 1'b1;
          w_hit_data[f*VFULEN +: VFULEN] = rd_rsp_data[j*VFULEN +: VFULEN];
        end
      end
    end
  end

  // Collecting accepts data for slots still awaited; draining only retires outstanding grants.
  always_comb begin
    w_take = '0;
    if (r_state == S_COLLECT) w_take = w_hit_slot & r_need_rsp;
    else if (r_state == S_DRAIN) w_take = w_hit_slot & r_inflight;
    w_grant       = rd_req_vld & rd_req_gnt;
    w_need_rsp_nx = r_need_rsp & ~w_take;
    w_inflight_nx = r_inflight & ~w_take;
  end

  assign uop_rdy      = (r_state == S_IDLE) & ~flush & ~rst;
  assign rd_req_vld   = r_need_req & {NSRC{r_state == S_COLLECT}};
  assign rd_req_vaddr = r_vaddr;
  assign rd_req_rs_idx = {NSRC{r_tag}};
  assign opnd_vld     = r_opnd_vld;
  assign opnd_vsb_idx = r_tag;
  assign opnd_src_vld = r_src_vld;
  assign opnd_data    = r_data;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_field
    assign rd_req_field[gi*2 +: 2] = 2'(gi);
  end

  // Uop life cycle: accept, request/collect, present, with a drain path after a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tag      <= '0;
      r_src_vld  <= '0;
      r_vaddr    <= '0;
      r_need_req <= '0;
      r_need_rsp <= '0;
      r_inflight <= '0;
      r_data     <= '0;
      r_opnd_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (uop_vld && uop_rdy) begin
            r_tag      <= uop_vsb_idx;
            r_src_vld  <= uop_src_vld;
            r_vaddr    <= uop_src_vaddr;
            r_need_req <= uop_src_vld;
            r_need_rsp <= uop_src_vld;
            r_inflight <= '0;
            r_data     <= '0;
            if (uop_src_vld == '0) begin
              r_state    <= S_SEND;
              r_opnd_vld <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          for (int f = 0; f < NSRC; f++) begin
            if (w_take[f]) r_data[f*VFULEN +: VFULEN] <= w_hit_data[f*VFULEN +: VFULEN];
          end
          if (flush) begin
            // A grant coinciding with flush is refused, so only earlier grants are drained.
            r_need_req <= '0;
            r_need_rsp <= '0;
            r_inflight <= w_inflight_nx;
            r_state    <= (|w_inflight_nx) ? S_DRAIN : S_IDLE;
          end else begin
            r_need_req <= r_need_req & ~w_grant;
            r_need_rsp <= w_need_rsp_nx;
            r_inflight <= w_inflight_nx | w_grant;
            if (w_need_rsp_nx == '0) begin
              r_state    <= S_SEND;
              r_opnd_vld <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (flush || opnd_rdy) begin
            r_opnd_vld <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          r_inflight <= w_inflight_nx;
          if (w_inflight_nx == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rrv64_vec_opnd_collector.sv
// Bench for the operand collector: directed scenarios with literal expectations, then random traffic.
// A transaction-level model tracks the uop and is compared against the DUT every cycle.
// A simple VRF responder grants randomly and returns data after 1..5 cycles in any order.
module tb_rrv64_vec_opnd_collector;
  localparam int VF = 256;
  localparam int VA = 6;
  localparam int VS = 16;
  localparam int NS = 3;
  localparam int MI = 0, MC = 1, MS = 2, MD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0, uop_vld = 1'b0, uop_rdy, opnd_vld, opnd_rdy = 1'b0;
  logic [VS-1:0]    uop_vsb_idx = '0, opnd_vsb_idx;
  logic [NS-1:0]    uop_src_vld = '0, rd_req_vld, rd_req_gnt = '0, rd_rsp_vld = '0, opnd_src_vld;
  logic [NS*VA-1:0] uop_src_vaddr = '0, rd_req_vaddr;
  logic [NS*VS-1:0] rd_req_rs_idx, rd_rsp_rs_idx = '0;
  logic [NS*2-1:0]  rd_req_field, rd_rsp_field = '0;
  logic [NS*VF-1:0] rd_rsp_data = '0, opnd_data;

  rrv64_vec_opnd_collector dut (
    .clk(clk), .rst(rst), .flush(flush), .uop_vld(uop_vld), .uop_rdy(uop_rdy),
    .uop_vsb_idx(uop_vsb_idx), .uop_src_vld(uop_src_vld), .uop_src_vaddr(uop_src_vaddr),
    .rd_req_vld(rd_req_vld), .rd_req_vaddr(rd_req_vaddr), .rd_req_rs_idx(rd_req_rs_idx),
    .rd_req_field(rd_req_field), .rd_req_gnt(rd_req_gnt), .rd_rsp_vld(rd_rsp_vld),
    .rd_rsp_data(rd_rsp_data), .rd_rsp_rs_idx(rd_rsp_rs_idx), .rd_rsp_field(rd_rsp_field),
    .opnd_vld(opnd_vld), .opnd_rdy(opnd_rdy), .opnd_vsb_idx(opnd_vsb_idx),
    .opnd_src_vld(opnd_src_vld), .opnd_data(opnd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0, n_deliv = 0;
  bit chk_en = 1'b0;

  localparam logic [VF-1:0] DA = {8{32'h1111_0000}};
  localparam logic [VF-1:0] DB = {8{32'h2222_0001}};
  localparam logic [VF-1:0] DC = {8{32'h3333_0002}};

  task automatic chk(input string nm, input logic [NS*VF-1:0] act, input logic [NS*VF-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int               m_mode;
  logic [VS-1:0]    m_tag;
  logic [NS-1:0]    m_src, m_need_req, m_need_rsp, m_out;
  logic [NS*VA-1:0] m_vaddr;
  logic [NS*VF-1:0] m_data;

  always @(posedge clk) begin : model
    logic [NS-1:0] took, grant;
    int f;
    if (rst) begin
      m_mode = MI; m_tag = '0; m_src = '0; m_vaddr = '0;
      m_need_req = '0; m_need_rsp = '0; m_out = '0; m_data = '0;
    end else begin
      took = '0;
      for (int j = 0; j < NS; j++) begin
        f = int'(rd_rsp_field[j*2 +: 2]);
        if (rd_rsp_vld[j] && rd_rsp_rs_idx[j*VS +: VS] == m_tag && f < NS) begin
          if (!took[f] && m_mode == MC && m_need_rsp[f]) begin
            took[f] = 1'b1;
            m_data[f*VF +: VF] = rd_rsp_data[j*VF +: VF];
          end else if (!took[f] && m_mode == MD && m_out[f]) begin
            took[f] = 1'b1;
          end
        end
      end
      case (m_mode)
        MI: if (uop_vld && !flush) begin
          m_tag = uop_vsb_idx; m_src = uop_src_vld; m_vaddr = uop_src_vaddr;
          m_need_req = uop_src_vld; m_need_rsp = uop_src_vld; m_out = '0; m_data = '0;
          m_mode = (uop_src_vld == '0) ? MS : MC;
        end
        MC: begin
          m_need_rsp = m_need_rsp & ~took;
          m_out      = m_out & ~took;
          if (flush) begin
            m_need_req = '0; m_need_rsp = '0;
            m_mode = (m_out != '0) ? MD : MI;
          end else begin
            grant      = m_need_req & rd_req_gnt;
            m_need_req = m_need_req & ~grant;
            m_out      = m_out | grant;
            if (m_need_rsp == '0) m_mode = MS;
          end
        end
        MS: if (flush || opnd_rdy) m_mode = MI;
        MD: begin
          m_out = m_out & ~took;
          if (m_out == '0) m_mode = MI;
        end
        default: m_mode = MI;
      endcase
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("uop_rdy", uop_rdy, (m_mode == MI) && !flush && !rst);
      chk("rd_req_vld", rd_req_vld, (m_mode == MC) ? m_need_req : '0);
      if (m_mode == MC) begin
        for (int i = 0; i < NS; i++) begin
          if (m_need_req[i]) begin
            chk("rd_req_vaddr", rd_req_vaddr[i*VA +: VA], m_vaddr[i*VA +: VA]);
            chk("rd_req_rs_idx", rd_req_rs_idx[i*VS +: VS], m_tag);
            chk("rd_req_field", rd_req_field[i*2 +: 2], i);
          end
        end
      end
      chk("opnd_vld", opnd_vld, m_mode == MS);
      if (m_mode == MS) begin
        chk("opnd_vsb_idx", opnd_vsb_idx, m_tag);
        chk("opnd_src_vld", opnd_src_vld, m_src);
        chk("opnd_data", opnd_data, m_data);
        if (opnd_rdy && !flush && !rst) n_deliv++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct { int field; logic [VS-1:0] tag; int due; logic [VF-1:0] data; } pend_t;
  pend_t pend[$];

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic clr();
    rd_req_gnt = '0; rd_rsp_vld = '0; rd_rsp_data = '0; rd_rsp_rs_idx = '0; rd_rsp_field = '0;
  endtask

  task automatic put_uop(input logic [VS-1:0] tag, input logic [NS-1:0] src, input logic [NS*VA-1:0] va);
    uop_vld = 1'b1; uop_vsb_idx = tag; uop_src_vld = src; uop_src_vaddr = va;
  endtask

  task automatic put_rsp(input int lane, input int field, input logic [VS-1:0] tag, input logic [VF-1:0] d);
    rd_rsp_vld[lane] = 1'b1;
    rd_rsp_field[lane*2 +: 2] = 2'(field);
    rd_rsp_rs_idx[lane*VS +: VS] = tag;
    rd_rsp_data[lane*VF +: VF] = d;
  endtask

  function automatic logic [VF-1:0] rnd256();
    logic [VF-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // VRF stand-in: returns earlier grants after their delay, sprinkles junk, grants new requests.
  task automatic vrf_step();
    clr();
    if (rst) begin
      pend.delete();
      return;
    end
    for (int j = 0; j < NS; j++) begin
      int pick;
      pick = -1;
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].due <= cyc) begin pick = k; break; end
        end
      end
      if (pick >= 0) begin
        put_rsp(j, pend[pick].field, pend[pick].tag, pend[pick].data);
        pend.delete(pick);
      end else if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) put_rsp(j, int'($urandom_range(0, 3)), '0, rnd256());
        else put_rsp(j, 3, rd_req_rs_idx[VS-1:0], rnd256());
      end
    end
    if (!flush) begin
      for (int i = 0; i < NS; i++) begin
        if (rd_req_vld[i] && $urandom_range(0, 2) != 0) begin
          rd_req_gnt[i] = 1'b1;
          pend.push_back('{field: int'(rd_req_field[i*2 +: 2]), tag: rd_req_rs_idx[i*VS +: VS],
                           due: cyc + int'($urandom_range(1, 5)), data: rnd256()});
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset
    tick(); chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_uop_rdy", uop_rdy, 0);
    chk("rst_opnd_vld", opnd_vld, 0);
    chk("rst_req_vld", rd_req_vld, 0);
    chk("rst_opnd_data", opnd_data, 0);
    chk("rst_opnd_vsb", opnd_vsb_idx, 0);
    tick(); rst = 1'b0;
    tick();

    // 1: two sources, same-cycle grant, response one cycle later
    tick(); put_uop(16'h0004, 3'b011, {6'd0, 6'd9, 6'd5});
    @(negedge clk); chk("t1_uop_rdy", uop_rdy, 1);
    tick(); uop_vld = 1'b0; rd_req_gnt = 3'b011;
    @(negedge clk); chk("t1_req_vld", rd_req_vld, 3'b011);
    chk("t1_vaddr1", rd_req_vaddr[11:6], 9);
    tick(); clr(); put_rsp(0, 0, 16'h0004, DA); put_rsp(1, 1, 16'h0004, DB);
    @(negedge clk); chk("t1_vld_early", opnd_vld, 0);
    tick(); clr(); opnd_rdy = 1'b1;
    @(negedge clk); chk("t1_opnd_vld", opnd_vld, 1);
    chk("t1_data", opnd_data, {256'h0, DB, DA});
    chk("t1_model_data", m_data, {256'h0, DB, DA});
    chk("t1_vsb", opnd_vsb_idx, 16'h0004);
    tick(); opnd_rdy = 1'b0;
    @(negedge clk); chk("t1_idle_rdy", uop_rdy, 1);

    // 2: three sources, lane 2 granted late, responses return as fields 2,0,1
    tick(); put_uop(16'h0010, 3'b111, {6'd3, 6'd2, 6'd1});
    tick(); uop_vld = 1'b0; rd_req_gnt = 3'b011;
    @(negedge clk); chk("t2_req_all", rd_req_vld, 3'b111);
    tick(); clr();
    tick();
    tick();
    @(negedge clk); chk("t2_req_held", rd_req_vld, 3'b100);
    chk("t2_vaddr2", rd_req_vaddr[17:12], 3);
    tick(); rd_req_gnt = 3'b100;
    tick(); clr(); put_rsp(0, 2, 16'h0010, DC);
    @(negedge clk); chk("t2_req_done", rd_req_vld, 0);
    tick(); clr(); put_rsp(2, 0, 16'h0010, DA);
    tick(); clr(); put_rsp(1, 1, 16'h0010, DB);
    @(negedge clk); chk("t2_vld_early", opnd_vld, 0);
    tick(); clr(); opnd_rdy = 1'b1;
    @(negedge clk); chk("t2_opnd_vld", opnd_vld, 1);
    chk("t2_data", opnd_data, {DC, DB, DA});
    tick(); opnd_rdy = 1'b0;

    // 3: response carrying a foreign tag is ignored
    tick(); put_uop(16'h0004, 3'b001, 18'd7);
    tick(); uop_vld = 1'b0; rd_req_gnt = 3'b001;
    tick(); clr(); put_rsp(0, 0, 16'h0008, DB);
    tick(); clr(); put_rsp(1, 0, 16'h0004, DA);
    @(negedge clk); chk("t3_ignored", opnd_vld, 0);
    tick(); clr(); opnd_rdy = 1'b1;
    @(negedge clk); chk("t3_opnd_vld", opnd_vld, 1);
    chk("t3_data", opnd_data, {256'h0, 256'h0, DA});
    tick(); opnd_rdy = 1'b0;

    // 4: flush after two of three grants, drain both responses
    tick(); put_uop(16'h0002, 3'b111, {6'd12, 6'd11, 6'd10});
    tick(); uop_vld = 1'b0; rd_req_gnt = 3'b001;
    tick(); rd_req_gnt = 3'b010;
    tick(); clr(); flush = 1'b1;
    @(negedge clk); chk("t4_rdy_in_flush", uop_rdy, 0);
    tick(); flush = 1'b0; put_rsp(1, 0, 16'h0002, DA);
    @(negedge clk); chk("t4_req_dropped", rd_req_vld, 0);
    chk("t4_model_drain", m_mode, MD);
    chk("t4_draining", uop_rdy, 0);
    tick(); clr(); put_rsp(0, 1, 16'h0002, DB);
    @(negedge clk); chk("t4_still_drain", uop_rdy, 0);
    tick(); clr();
    @(negedge clk); chk("t4_idle", uop_rdy, 1);
    chk("t4_no_opnd", opnd_vld, 0);

    // 5: no sources, result held under backpressure
    tick(); put_uop(16'h8000, 3'b000, 18'h3ffff);
    tick(); uop_vld = 1'b0;
    @(negedge clk); chk("t5_opnd_vld", opnd_vld, 1);
    chk("t5_data", opnd_data, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk); chk("t5_hold_vld", opnd_vld, 1);
      chk("t5_hold_vsb", opnd_vsb_idx, 16'h8000);
      chk("t5_hold_data", opnd_data, 0);
    end
    tick(); opnd_rdy = 1'b1;
    @(negedge clk); chk("t5_no_rdy_in_send", uop_rdy, 0);
    tick(); opnd_rdy = 1'b0;
    @(negedge clk); chk("t5_released", opnd_vld, 0);
    chk("t5_idle", uop_rdy, 1);

    // 6: reset while collecting
    tick(); put_uop(16'h0001, 3'b111, 18'h0);
    tick(); uop_vld = 1'b0;
    @(negedge clk); chk("t6_req", rd_req_vld, 3'b111);
    tick(); rst = 1'b1;
    @(negedge clk); chk("t6_rdy_rst", uop_rdy, 0);
    tick();
    @(negedge clk); chk("t6_req_clr", rd_req_vld, 0);
    chk("t6_opnd_clr", opnd_vld, 0);
    chk("t6_rdy_held", uop_rdy, 0);
    tick(); rst = 1'b0;
    @(negedge clk); chk("t6_rdy_back", uop_rdy, 1);

    // Random traffic
    d0 = n_deliv;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst           = ($urandom_range(0, 299) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      uop_vld       = ($urandom_range(0, 1) == 1);
      uop_vsb_idx   = 16'h1 << $urandom_range(0, 15);
      uop_src_vld   = 3'($urandom_range(0, 7));
      uop_src_vaddr = 18'($urandom);
      opnd_rdy      = ($urandom_range(0, 2) != 0);
      vrf_step();
    end
    uop_vld = 1'b0; flush = 1'b0; rst = 1'b0; opnd_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      vrf_step();
    end
    tick(); clr();
    @(negedge clk); chk("rand_quiesced", uop_rdy, 1);
    chk("rand_delivered", n_deliv - d0 > 20, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
